// File: rtl/writeback_scheduler.sv
// Merges ALU results and FIFO-buffered load results onto one registered write port.
// Latency: ALU results take 1 cycle and loads at least 2; ALU always wins; ld_ready drops only while the FIFO is full.
module writeback_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [4:0]        issue_reg,
    input  logic              alu_valid,
    input  logic [4:0]        alu_reg,
    input  logic [31:0]       alu_data,
    input  logic              ld_valid,
    input  logic [4:0]        ld_reg,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    input  logic [4:0]        query_reg1,
    input  logic [4:0]        query_reg2,
    output logic              busy1,
    output logic              busy2,
    output logic [4:0]        write_reg,
    output logic [31:0]       write_data,
    output logic              write_enable,
    output logic [ADDR_W:0]   queue_count
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [4:0]        fifo_reg  [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic [31:0]       pending;
    logic              push;
    logic              pop;
    logic [4:0]        head_reg;
    logic [31:0]       head_data;
    logic [31:0]       sb_set;
    logic [31:0]       sb_clr;

    // Fullness comes from the registered count, so a same-edge pop never frees a slot early.
    assign ld_ready    = (count != FULL);
    assign queue_count = count;
    assign push        = ld_valid && ld_ready;
    assign pop         = !alu_valid && (count != '0);
    assign head_reg    = fifo_reg[rd_ptr];
    assign head_data   = fifo_data[rd_ptr];
    assign busy1       = pending[query_reg1];
    assign busy2       = pending[query_reg2];

    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (issue_valid && issue_reg != 5'd0)
            sb_set[issue_reg] = 1'b1;
        if (pop)
            sb_clr[head_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            pending      <= '0;
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            if (alu_valid) begin
                write_enable <= (alu_reg != 5'd0);
                write_reg    <= alu_reg;
                write_data   <= alu_data;
            end else if (pop) begin
                write_enable <= (head_reg != 5'd0);
                write_reg    <= head_reg;
                write_data   <= head_data;
            end else begin
                write_enable <= 1'b0;
            end

            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase

            // Set is applied after clear so a re-issued load keeps its register busy.
            pending <= (pending & ~sb_clr) | sb_set;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= ld_reg;
            fifo_data[wr_ptr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_writeback_scheduler.sv
// Randomized and directed bench for writeback_scheduler, with a queue-based reference model and scoreboard.
module tb_writeback_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, issue_valid, alu_valid, ld_valid;
    logic [4:0]  issue_reg, alu_reg, ld_reg, query_reg1, query_reg2;
    logic [31:0] alu_data, ld_data;
    logic        ld_ready, busy1, busy2, write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [2:0]  queue_count;

    writeback_scheduler #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
        .query_reg1(query_reg1), .query_reg2(query_reg2), .busy1(busy1), .busy2(busy2),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        all;
        logic [4:0]  r;
        logic [31:0] d;
    } wexp_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ld_t;

    wexp_t       expq[$];
    ld_t         mq[$];
    logic [31:0] pend;
    bit          model_ok = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected write-port state per clock edge.
    initial begin
        wexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("write_enable", {31'd0, write_enable}, {31'd0, e.en});
                if (e.en || e.all) begin
                    chk("write_reg", {27'd0, write_reg}, {27'd0, e.r});
                    chk("write_data", write_data, e.d);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic iv, input logic [4:0] ir,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic [4:0] q1, input logic [4:0] q2);
        wexp_t e;
        ld_t   h;
        bit    accept;
        @(negedge clk);
        query_reg1 = q1;
        query_reg2 = q2;
        #1;
        if (model_ok) begin
            chk("queue_count", {29'd0, queue_count}, mq.size());
            chk("ld_ready", {31'd0, ld_ready}, {31'd0, mq.size() != DEPTH});
            chk("busy1", {31'd0, busy1}, {31'd0, pend[q1]});
            chk("busy2", {31'd0, busy2}, {31'd0, pend[q2]});
        end
        reset = rst; issue_valid = iv; issue_reg = ir;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        ld_valid = lv; ld_reg = lr; ld_data = ld;

        e = '{en: 1'b0, all: 1'b0, r: 5'd0, d: 32'd0};
        if (rst) begin
            e.all = 1'b1;
            mq.delete();
            pend = '0;
            model_ok = 1;
        end else begin
            accept = lv && (mq.size() != DEPTH);
            if (av) begin
                e.en = (ar != 0); e.r = ar; e.d = ad;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                e.en = (h.r != 0); e.r = h.r; e.d = h.d;
                pend[h.r] = 1'b0;
            end
            if (accept) mq.push_back('{r: lr, d: ld});
            if (iv && ir != 0) pend[ir] = 1'b1;
        end
        if (model_ok) expq.push_back(e);
    endtask

    task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    initial begin
        pend = '0;
        reset = 1'b1; issue_valid = 0; issue_reg = 0; alu_valid = 0; alu_reg = 0; alu_data = 0;
        ld_valid = 0; ld_reg = 0; ld_data = 0; query_reg1 = 0; query_reg2 = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 5'd3, 5'd17);

        // Single ALU write.
        step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5, 5'd0);
        idle(2, 5'd5, 5'd0);

        // Load to r8 contending with a 3-cycle ALU burst.
        step(0, 1, 5'd8, 0, 0, 0, 0, 0, 0, 5'd8, 5'd8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd1);
        step(0, 0, 0, 1, 5'd10, 32'hA0, 1, 5'd8, 32'h12345678, 5'd8, 5'd10);
        step(0, 0, 0, 1, 5'd11, 32'hA1, 0, 0, 0, 5'd8, 5'd11);
        step(0, 0, 0, 1, 5'd12, 32'hA2, 0, 0, 0, 5'd8, 5'd12);
        idle(3, 5'd8, 5'd8);

        // Fill the FIFO under ALU pressure; the fifth load must be refused.
        for (int i = 1; i <= 5; i++)
            step(0, 1, 5'(i), 1, 5'd20, 32'h100 + i, 1, 5'(i), 32'hB00 + i, 5'd1, 5'd4);
        step(0, 0, 0, 1, 5'd21, 32'h200, 1, 5'd5, 32'hB05, 5'd2, 5'd3);
        idle(6, 5'd1, 5'd4);

        // Load to r0 is popped without a write.
        step(0, 1, 5'd0, 0, 0, 0, 1, 5'd0, 32'hCAFE, 5'd0, 5'd0);
        idle(3, 5'd0, 5'd0);

        // Re-issue of r9 on the edge its previous load pops.
        step(0, 1, 5'd9, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h99, 5'd9, 5'd9);
        step(0, 1, 5'd9, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
        idle(2, 5'd9, 5'd9);
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h999, 5'd9, 5'd9);
        idle(3, 5'd9, 5'd9);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'(12 + i), 1, 5'd22, 32'h300 + i, 1, 5'(12 + i), 32'hC00 + i, 5'd12, 5'd13);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd14);
        idle(5, 5'd12, 5'd13);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom),
                 $urandom_range(0, 2) == 0, 5'($urandom), $urandom,
                 $urandom_range(0, 1) == 0, 5'($urandom), $urandom,
                 5'($urandom), 5'($urandom));
        end
        idle(8, 5'd0, 5'd31);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
